// File: rtl/sram_icb_bist_master_pkg.sv
// Shared definitions for the SRAM ICB BIST master: ICB user tags and FSM state encoding.
package sram_icb_bist_master_pkg;

  // ICB usr tag carried on commands and echoed on responses
  localparam logic USR_TAG_WR = 1'b0;
  localparam logic USR_TAG_RD = 1'b1;

  // One-hot FSM state encoding
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_WR_CMD = 6'b000010,
    ST_WR_RSP = 6'b000100,
    ST_RD_CMD = 6'b001000,
    ST_RD_RSP = 6'b010000,
    ST_FIN    = 6'b100000
  } state_e;

endpackage

// File: rtl/sram_icb_bist_addr_gen.sv
// Word index counter for the BIST master: holds the run parameters latched at start,
// produces the byte address and expected pattern for the current word, and flags the last word.
module sram_icb_bist_addr_gen #(
  parameter int DW     = 32,
  parameter int AW     = 19,
  parameter int AW_LSB = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [AW-1:0]        base_i,
  input  logic [AW-AW_LSB-1:0] cnt_i,
  input  logic [DW-1:0]        seed_i,
  output logic [AW-1:0]        addr_o,
  output logic [DW-1:0]        pattern_o,
  output logic                 last_o
);

  localparam int IW = AW - AW_LSB;

  logic [AW-1:0] base_q;
  logic [IW-1:0] cnt_q;
  logic [DW-1:0] seed_q;
  logic [IW-1:0] idx_q, idx_d;

  // Next index: load/clear win over increment
  always_comb begin
    idx_d = idx_q;
    if (load_i || clr_i) idx_d = '0;
    else if (inc_i)      idx_d = idx_q + IW'(1);
  end

  // Latch run parameters at start (byte offset within a word is dropped) and advance the index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      seed_q <= '0;
      idx_q  <= '0;
    end else begin
      if (load_i) begin
        base_q <= base_i & ~AW'((1 << AW_LSB) - 1);
        cnt_q  <= cnt_i;
        seed_q <= seed_i;
      end
      idx_q <= idx_d;
    end
  end

  // Address and pattern wrap silently at their widths
  assign addr_o    = base_q + (AW'(idx_q) << AW_LSB);
  assign pattern_o = seed_q + DW'(idx_q);
  assign last_o    = (idx_q == cnt_q - IW'(1));

endmodule

// File: rtl/sram_icb_bist_master.sv
// ICB initiator that writes seed+i to a word range, reads it back and reports the first mismatch.
// One outstanding transaction at a time.
//
// state  | meaning
// IDLE   | waiting for start
// WR_CMD | write command presented, waiting for cmd_ready
// WR_RSP | waiting for write response
// RD_CMD | read command presented, waiting for cmd_ready
// RD_RSP | waiting for read response, compare against pattern
// FIN    | one-cycle done pulse, then back to IDLE
module sram_icb_bist_master
  import sram_icb_bist_master_pkg::*;
#(
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int AW     = 19,
  parameter int AW_LSB = 2,
  parameter int USR_W  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-AW_LSB-1:0] word_cnt,
  input  logic [DW-1:0]        seed,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [AW-1:0]        fail_addr,
  output logic [DW-1:0]        fail_data,
  output logic                 o_icb_cmd_valid,
  input  logic                 o_icb_cmd_ready,
  output logic                 o_icb_cmd_read,
  output logic [AW-1:0]        o_icb_cmd_addr,
  output logic [DW-1:0]        o_icb_cmd_wdata,
  output logic [MW-1:0]        o_icb_cmd_wmask,
  output logic [USR_W-1:0]     o_icb_cmd_usr,
  input  logic                 o_icb_rsp_valid,
  output logic                 o_icb_rsp_ready,
  input  logic [DW-1:0]        o_icb_rsp_rdata,
  input  logic [USR_W-1:0]     o_icb_rsp_usr
);

  state_e        state_q;
  logic          busy_q, done_q, fail_q;
  logic [AW-1:0] fail_addr_q;
  logic [DW-1:0] fail_data_q;
  logic          cmd_valid_q, cmd_read_q, rsp_ready_q;

  logic          load, idx_clr, idx_inc;
  logic          wr_acc, rd_acc, last, mismatch;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_pat;

  sram_icb_bist_addr_gen #(
    .DW     (DW),
    .AW     (AW),
    .AW_LSB (AW_LSB)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .clr_i     (idx_clr),
    .inc_i     (idx_inc),
    .base_i    (base_addr),
    .cnt_i     (word_cnt),
    .seed_i    (seed),
    .addr_o    (cur_addr),
    .pattern_o (cur_pat),
    .last_o    (last)
  );

  // Response acceptance, comparison and index control
  always_comb begin
    load     = (state_q == ST_IDLE) && start;
    wr_acc   = (state_q == ST_WR_RSP) && o_icb_rsp_valid;
    rd_acc   = (state_q == ST_RD_RSP) && o_icb_rsp_valid;
    mismatch = (o_icb_rsp_rdata != cur_pat) || (o_icb_rsp_usr != USR_W'(USR_TAG_RD));
    idx_clr  = wr_acc && last;
    idx_inc  = (wr_acc && !last) || (rd_acc && !mismatch && !last);
  end

  // Sequencing FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            if (word_cnt == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q     <= ST_WR_CMD;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b0;
            end
          end
        end
        ST_WR_CMD: begin
          if (o_icb_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= ST_WR_RSP;
          end
        end
        ST_WR_RSP: begin
          if (o_icb_rsp_valid) begin
            rsp_ready_q <= 1'b0;
            cmd_valid_q <= 1'b1;
            if (last) begin
              cmd_read_q <= 1'b1;
              state_q    <= ST_RD_CMD;
            end else begin
              state_q <= ST_WR_CMD;
            end
          end
        end
        ST_RD_CMD: begin
          if (o_icb_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= ST_RD_RSP;
          end
        end
        ST_RD_RSP: begin
          if (o_icb_rsp_valid) begin
            rsp_ready_q <= 1'b0;
            if (mismatch) begin
              fail_q      <= 1'b1;
              fail_addr_q <= cur_addr;
              fail_data_q <= o_icb_rsp_rdata;
              state_q     <= ST_FIN;
            end else if (last) begin
              state_q <= ST_FIN;
            end else begin
              cmd_valid_q <= 1'b1;
              state_q     <= ST_RD_CMD;
            end
          end
        end
        ST_FIN: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          cmd_read_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_addr       = fail_addr_q;
  assign fail_data       = fail_data_q;
  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_cmd_read  = cmd_read_q;
  assign o_icb_cmd_addr  = cur_addr;
  assign o_icb_cmd_wdata = cur_pat;
  assign o_icb_cmd_wmask = {MW{cmd_valid_q & ~cmd_read_q}};
  assign o_icb_cmd_usr   = cmd_read_q ? USR_W'(USR_TAG_RD) : USR_W'(USR_TAG_WR);
  assign o_icb_rsp_ready = rsp_ready_q;

endmodule

// File: tb/tb_sram_icb_bist_master.sv
// Scoreboard bench for sram_icb_bist_master with a behavioural ICB memory slave.
module tb_sram_icb_bist_master;

  typedef struct packed {
    logic        rd;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        usr;
  } cmd_t;

  typedef struct packed {
    logic        f;
    logic [18:0] fa;
    logic [31:0] fd;
    logic [15:0] lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic [16:0] word_cnt = '0;
  logic [31:0] seed = '0;
  logic        busy, done, fail;
  logic [18:0] fail_addr;
  logic [31:0] fail_data;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [18:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic [0:0]  cmd_usr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [0:0]  rsp_usr;

  sram_icb_bist_master dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .word_cnt        (word_cnt),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .fail            (fail),
    .fail_addr       (fail_addr),
    .fail_data       (fail_data),
    .o_icb_cmd_valid (cmd_valid),
    .o_icb_cmd_ready (cmd_ready),
    .o_icb_cmd_read  (cmd_read),
    .o_icb_cmd_addr  (cmd_addr),
    .o_icb_cmd_wdata (cmd_wdata),
    .o_icb_cmd_wmask (cmd_wmask),
    .o_icb_cmd_usr   (cmd_usr),
    .o_icb_rsp_valid (rsp_valid),
    .o_icb_rsp_ready (rsp_ready),
    .o_icb_rsp_rdata (rsp_rdata),
    .o_icb_rsp_usr   (rsp_usr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_pass = 0;
  cmd_t exp_cmd_q[$];
  res_t exp_res_q[$];
  int   start_cyc = 0;
  bit   done_seen = 0;

  // slave configuration
  int          stall_n = 0;
  bit          cor_en = 0;
  logic [18:0] cor_addr = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // ---------------- behavioural ICB memory slave ----------------
  logic [31:0] mem [0:1023];
  int          wait_c = 0;
  initial begin
    bit          hs_c, hs_r;
    logic        c_rd;
    logic [18:0] c_addr;
    logic [31:0] c_wdata;
    logic [0:0]  c_usr;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_usr   = '0;
    forever begin
      @(negedge clk);
      hs_c    = cmd_valid && cmd_ready && !rst;
      hs_r    = rsp_valid && rsp_ready && !rst;
      c_rd    = cmd_read;
      c_addr  = cmd_addr;
      c_wdata = cmd_wdata;
      c_usr   = cmd_usr;
      @(posedge clk);
      #1;
      if (rst) begin
        rsp_valid = 1'b0;
        cmd_ready = (stall_n == 0);
        wait_c    = 0;
      end else begin
        if (hs_r) rsp_valid = 1'b0;
        if (hs_c) begin
          if (!c_rd) begin
            mem[c_addr[11:2]] = c_wdata;
            rsp_rdata = '0;
          end else begin
            rsp_rdata = mem[c_addr[11:2]] ^ ((cor_en && c_addr == cor_addr) ? 32'h1 : 32'h0);
          end
          rsp_usr   = c_usr;
          rsp_valid = 1'b1;
        end
        if (stall_n == 0) cmd_ready = 1'b1;
        else if (hs_c) begin
          cmd_ready = 1'b0;
          wait_c    = 0;
        end else if (cmd_valid) begin
          if (wait_c >= stall_n) cmd_ready = 1'b1;
          else begin
            wait_c++;
            cmd_ready = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- monitor: pops and compares ----------------
  initial begin
    cmd_t cur, held, e;
    res_t r, er;
    bit   stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur = {cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr};
        if (cmd_valid && !cmd_ready) begin
          if (stalled) chk("stall_stable", 64'(cur), 64'(held));
          held    = cur;
          stalled = 1;
        end else stalled = 0;
        if (cmd_valid && cmd_ready) begin
          if (cur.rd) begin
            cur.wdata = '0;
            cur.wmask = '0;
          end
          if (exp_cmd_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_cmd: got %h expected none", cur);
          end else begin
            e = exp_cmd_q.pop_front();
            chk("cmd", 64'(cur), 64'(e));
          end
        end
        if (done) begin
          done_seen = 1;
          r = {fail, fail_addr, fail_data, 16'(cyc - start_cyc)};
          chk("busy_at_done", 64'(busy), 64'd0);
          if (exp_res_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got %h expected none", r);
          end else begin
            er = exp_res_q.pop_front();
            chk("result_fail_addr_data_lat", 64'(r), 64'(er));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({busy, done, fail, cmd_valid, cmd_read, rsp_ready, cmd_wmask, cmd_usr}), 64'd0);
    chk({nm, "_addr"}, 64'({cmd_addr, fail_addr}), 64'd0);
    chk({nm, "_wdata"}, 64'(cmd_wdata), 64'd0);
    chk({nm, "_fdata"}, 64'(fail_data), 64'd0);
  endtask

  task automatic launch(input logic [18:0] base, input logic [16:0] cnt, input logic [31:0] sd,
                        input int stall, input bit cen, input logic [18:0] ca,
                        input logic ef, input logic [18:0] efa, input logic [31:0] efd, input int elat);
    logic [18:0] a;
    @(negedge clk);
    stall_n  = stall;
    cor_en   = cen;
    cor_addr = ca;
    for (int i = 0; i < int'(cnt); i++) begin
      a = (base & ~19'h3) + 19'(i * 4);
      exp_cmd_q.push_back({1'b0, a, sd + 32'(i), 4'hF, 1'b0});
    end
    for (int i = 0; i < int'(cnt); i++) begin
      a = (base & ~19'h3) + 19'(i * 4);
      exp_cmd_q.push_back({1'b1, a, 32'h0, 4'h0, 1'b1});
      if (cen && a == ca) break;
    end
    exp_res_q.push_back({ef, efa, efd, 16'(elat)});
    @(posedge clk);
    #1;
    base_addr = base;
    word_cnt  = cnt;
    seed      = sd;
    start     = 1'b1;
    start_cyc = cyc;
    done_seen = 0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 19'h5554;
    word_cnt  = 17'h1;
    seed      = 32'hDEAD_BEEF;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done_seen && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (!done_seen) begin
      n_checks++;
      $display("FAIL %s_timeout: done not seen, expected within 400 cycles", nm);
    end
    @(negedge clk);
    chk({nm, "_cmd_queue_empty"}, 64'(exp_cmd_q.size()), 64'd0);
    exp_cmd_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // basic run: 8 words at 2 cycles each plus start/FIN overhead
    launch(19'h100, 17'd4, 32'hA5A5_0000, 0, 0, 19'h0, 1'b0, 19'h0, 32'h0, 18);
    wait_done("basic");

    // 3-cycle cmd stall on every command, plus start pulse while busy and input changes
    launch(19'h100, 17'd4, 32'hA5A5_0000, 3, 0, 19'h0, 1'b0, 19'h0, 32'h0, 42);
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    word_cnt = 17'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("stall");

    // corrupted read of word 2 aborts before word 3 is read
    launch(19'h100, 17'd4, 32'hA5A5_0000, 0, 1, 19'h108, 1'b1, 19'h108, 32'hA5A5_0003, 16);
    wait_done("corrupt");

    // empty run clears the sticky fail and issues nothing
    launch(19'h100, 17'd0, 32'h1111_1111, 0, 0, 19'h0, 1'b0, 19'h0, 32'h0, 2);
    wait_done("empty");

    // address wrap past the top of the space
    launch(19'h7FFFE, 17'd2, 32'h1234_5678, 0, 0, 19'h0, 1'b0, 19'h0, 32'h0, 10);
    wait_done("wrap");

    // reset while waiting for a read response
    launch(19'h100, 17'd4, 32'h0BAD_0000, 0, 0, 19'h0, 1'b0, 19'h0, 32'h0, 0);
    begin
      int k = 0;
      while (!(rsp_ready && cmd_read) && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!(rsp_ready && cmd_read)) begin
        n_checks++;
        $display("FAIL midrst_reach: RD_RSP not reached, expected within 100 cycles");
      end
    end
    #1;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    exp_cmd_q.delete();
    exp_res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // pattern wraps modulo 2^32 after reset
    launch(19'h200, 17'd3, 32'hFFFF_FFFE, 0, 0, 19'h0, 1'b0, 19'h0, 32'h0, 14);
    wait_done("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
